spi_master: RTL and testbench

Single-clock SPI master that drives the opposite end of the team's SPI slave link: it accepts 10-bit command words from a host over a valid/ready handshake, serialises them MSB-first on `MOSI` under `SS_n`, and for read-data commands captures the 8-bit response returned on `MISO`. It sits between the host/register-access logic and the slave (RAM-side) interface. `SS_n` framing and bit timing are clocked directly by `clk`; the slave samples on the same clock.

---
 rtl/spi_master.sv | 99 +++++++++
 tb/tb_spi_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: serialises 10-bit command words MSB-first under SS_n and, for
// read-data commands, shifts an 8-bit response in from miso.
module spi_master #(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_word,
  output logic       cmd_ready,
  input  logic       miso,
  output logic       SS_n,
  output logic       MOSI,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  typedef enum logic [2:0] {
    IDLE, START, CMD, SHIFT, HOLD, WAIT, READ, GAP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [9:0] word;
  logic [6:0] shreg;
  logic       ss_nxt, mosi_nxt;
  logic       gap_last, accept, read_done;

  // The last GAP cycle also accepts, so a new frame can start on the edge
  // that ends the gap and SS_n stays high for exactly IDLE_GAP cycles.
  assign gap_last  = (state == GAP) && (cnt == GAP_LAST);
  assign cmd_ready = (state == IDLE) || gap_last;
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign read_done = (state == READ) && (cnt == 4'd7);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = START;
      START:   state_nxt = CMD;
      CMD:     state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd9) state_nxt = (word[9:8] == 2'b11) ? WAIT : HOLD;
      HOLD:    state_nxt = GAP;
      WAIT:    if (cnt == WAIT_LAST) state_nxt = READ;
      READ:    if (cnt == 4'd7) state_nxt = GAP;
      GAP:     if (cnt == GAP_LAST) state_nxt = cmd_valid ? START : IDLE;
      default: state_nxt = IDLE;
    endcase

    if ((state_nxt != state) || (state_nxt == IDLE)) cnt_nxt = 4'd0;
    else cnt_nxt = cnt + 4'd1;

    // Outputs are decoded from the upcoming state so the registers present
    // them in the same cycle that state becomes current.
    ss_nxt   = (state_nxt == IDLE) || (state_nxt == GAP);
    mosi_nxt = 1'b0;
    case (state_nxt)
      CMD:     mosi_nxt = word[9];
      SHIFT:   mosi_nxt = word[4'd9 - cnt_nxt];
      default: mosi_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= 10'd0;
      shreg    <= 7'd0;
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      if (accept) word <= cmd_word;
      if (state == READ) shreg <= {shreg[5:0], miso};
      // The eighth bit goes straight into rd_data on the edge that leaves READ.
      if (read_done) rd_data <= {shreg, miso};
      rd_valid <= read_done;
      SS_n     <= ss_nxt;
      MOSI     <= mosi_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: per-cycle expected-waveform queue built from the frame
// format, plus a slave model that decodes MOSI and answers read-data on miso.
module tb_spi_master;

  localparam int RD_WAIT  = 2;
  localparam int IDLE_GAP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [9:0] cmd_word;
  logic       cmd_ready;
  logic       miso = 1'b0;
  logic       SS_n;
  logic       MOSI;
  logic       busy;
  logic [7:0] rd_data;
  logic       rd_valid;

  spi_master #(.RD_WAIT(RD_WAIT), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .cmd_ready(cmd_ready), .miso(miso), .SS_n(SS_n), .MOSI(MOSI),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ss;
    logic       mosi;
    logic       rdv;
    logic [7:0] rdd;
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  sent_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  model_rd = 8'h00;
  logic [7:0]  next_resp = 8'h00;
  logic [7:0]  slave_resp = 8'h00;
  int          cyc = 0, high_cnt = 0, last_low_len = 0, last_high_len = 0, rdv_count = 0;
  logic        in_frame = 1'b0;
  logic [31:0] mosi_log = 32'd0;
  logic [9:0]  rx_word = 10'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic ss, input logic mosi, input logic rdv, input logic [7:0] rdd);
    exp_t e;
    e.ss = ss; e.mosi = mosi; e.rdv = rdv; e.rdd = rdd;
    return e;
  endfunction

  // Whole frame as seen on the pins, one entry per cycle after the accept edge.
  function automatic void push_frame(input logic [9:0] w, input logic [7:0] resp);
    logic is_rd;
    is_rd = (w[9:8] == 2'b11);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00));
    exp_q.push_back(mk(1'b0, w[9], 1'b0, 8'h00));
    for (int i = 9; i >= 0; i--) exp_q.push_back(mk(1'b0, w[i], 1'b0, 8'h00));
    if (is_rd) begin
      for (int i = 0; i < RD_WAIT + 8; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00));
    end else begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00));
    end
    exp_q.push_back(mk(1'b1, 1'b0, is_rd, resp));
    for (int i = 1; i < IDLE_GAP; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00));
  endfunction

  always @(negedge clk) begin : compare_proc
    exp_t e;
    logic model_ready;
    if (rst) begin
      exp_q.delete();
      sent_q.delete();
      model_rd = 8'h00;
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b1, 1'b0, 1'b0, 8'h00);
      if (e.rdv) model_rd = e.rdd;
      model_ready = (exp_q.size() == 0);
      checkOutput("SS_n", SS_n, e.ss);
      checkOutput("MOSI", MOSI, e.mosi);
      checkOutput("rd_valid", rd_valid, e.rdv);
      checkOutput("rd_data", rd_data, model_rd);
      checkOutput("cmd_ready", cmd_ready, model_ready);
      checkOutput("busy", busy, !model_ready);
      if (cmd_valid && model_ready) begin
        push_frame(cmd_word, next_resp);
        sent_q.push_back(cmd_word);
        if (cmd_word[9:8] == 2'b11) slave_resp = next_resp;
      end
    end
  end

  // Slave model: decodes each frame from the pins and drives miso in the READ window.
  always @(negedge clk) begin : slave_proc
    if (rst) begin
      in_frame = 1'b0;
      cyc = 0;
      miso = 1'b0;
      high_cnt = 0;
    end else if (SS_n) begin
      if (in_frame) begin
        last_low_len = cyc;
        if (cyc >= 12) begin
          checkOutput("frame_len", cyc, (rx_word[9:8] == 2'b11) ? 20 + RD_WAIT : 13);
          checkOutput("slave_pending_cmds", sent_q.size() != 0, 1);
          if (sent_q.size() != 0) checkOutput("slave_word", rx_word, sent_q.pop_front());
        end
      end
      in_frame = 1'b0;
      cyc = 0;
      miso = 1'b0;
      high_cnt++;
    end else begin
      if (!in_frame) begin
        last_high_len = high_cnt;
        high_cnt = 0;
        mosi_log = 32'd0;
        in_frame = 1'b1;
      end
      mosi_log = {mosi_log[30:0], MOSI};
      if (cyc >= 2 && cyc <= 11) rx_word = {rx_word[8:0], MOSI};
      if (rx_word[9:8] == 2'b11 && cyc >= 12 + RD_WAIT && cyc <= 19 + RD_WAIT)
        miso = slave_resp[19 + RD_WAIT - cyc];
      else
        miso = 1'b0;
      cyc++;
    end
    if (!rst && rd_valid) rdv_count++;
  end

  task automatic applyStimulus(input logic [9:0] w, input logic [7:0] resp, input bit hold);
    int t;
    cmd_word  = w;
    next_resp = resp;
    cmd_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 200);
    if (!cmd_ready) checkOutput("accept_timeout", cmd_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (exp_q.size() != 0 && t < 300);
    if (exp_q.size() != 0) checkOutput("idle_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int rdv0, gap, next_gap;
    logic [9:0] w;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_word = 10'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_SS_n", SS_n, 1);
      checkOutput("idle_MOSI", MOSI, 0);
      checkOutput("idle_cmd_ready", cmd_ready, 1);
      checkOutput("idle_rd_data", rd_data, 8'h00);
    end
    @(posedge clk);
    #1;

    rdv0 = rdv_count;
    applyStimulus(10'b00_1010_0101, 8'h00, 1'b0);
    waitIdle();
    checkOutput("wa_low_len", last_low_len, 13);
    checkOutput("wa_mosi_seq", mosi_log[12:0], 32'b0_0000_1010_0101_0 >> 0);
    checkOutput("wa_no_rd_valid", rdv_count, rdv0);

    rdv0 = rdv_count;
    applyStimulus(10'b11_0000_0000, 8'hC3, 1'b0);
    waitIdle();
    checkOutput("rd_low_len", last_low_len, 20 + RD_WAIT);
    checkOutput("rd_data_c3", rd_data, 8'hC3);
    checkOutput("rd_one_pulse", rdv_count, rdv0 + 1);

    applyStimulus(10'b10_0001_1111, 8'h00, 1'b1);
    applyStimulus(10'b11_0101_0101, 8'h96, 1'b0);
    waitIdle();
    checkOutput("b2b_high_gap", last_high_len, IDLE_GAP);
    checkOutput("b2b_rd_data", rd_data, 8'h96);

    rdv0 = rdv_count;
    applyStimulus(10'b11_1111_0000, 8'hA5, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_SS_n", SS_n, 1);
    checkOutput("rst_MOSI", MOSI, 0);
    checkOutput("rst_rd_data", rd_data, 8'h00);
    checkOutput("rst_rd_valid", rd_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checkOutput("rst_no_pulse", rdv_count, rdv0);
    applyStimulus(10'b01_1100_1100, 8'h00, 1'b0);
    waitIdle();
    checkOutput("post_rst_len", last_low_len, 13);
    checkOutput("post_rst_rd_data", rd_data, 8'h00);

    gap = $urandom_range(0, 2);
    for (int n = 0; n < 40; n++) begin
      if (gap > 0) begin
        cmd_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      w = 10'($urandom);
      next_gap = $urandom_range(0, 2);
      applyStimulus(w, 8'($urandom), next_gap == 0);
      gap = next_gap;
    end
    cmd_valid = 1'b0;
    waitIdle();
    checkOutput("all_frames_decoded", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
